// File: rtl/dsp_nco_phase_det.sv
// Vectoring-mode CORDIC phase/magnitude detector with successive-phase difference output.
// One sample in flight at a time: IDLE -> PRE -> ITER (ITER micro-rotations) -> DONE.
`timescale 1ns/1ps

module dsp_nco_phase_det #(
    parameter int DATA_WIDTH = 16,
    parameter int PHI_WIDTH  = 16,
    parameter int ITER       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sin_i,
    input  logic [DATA_WIDTH-1:0] cos_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [PHI_WIDTH-1:0]  phase_o,
    output logic [PHI_WIDTH-1:0]  phi_inc_o,
    output logic [DATA_WIDTH:0]   mag_o,
    output logic                  out_valid,
    input  logic                  out_ready
);

    // Guard bits below the integer LSB stop the floor bias of >>> from piling up in X.
    localparam int GUARD = 4;
    localparam int XW    = DATA_WIDTH + 2 + GUARD;
    localparam int RSH   = (PHI_WIDTH < 32) ? 31 - PHI_WIDTH : 0;
    localparam logic [31:0]          ROUND = (PHI_WIDTH < 32) ? (32'd1 << RSH) : 32'd0;
    localparam logic signed [XW-1:0] HALF  = XW'(2 ** (GUARD - 1));
    localparam logic [4:0]           LAST  = 5'(ITER - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_ITER, ST_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_sin;
    logic [DATA_WIDTH-1:0] r_cos;
    logic                  r_zero;
    logic signed [XW-1:0]  r_x;
    logic signed [XW-1:0]  r_y;
    logic [31:0]           r_z;
    logic [4:0]            r_cnt;
    logic                  r_valid;
    logic                  r_first;
    logic [PHI_WIDTH-1:0]  r_phase;
    logic [PHI_WIDTH-1:0]  r_prev;
    logic [PHI_WIDTH-1:0]  r_inc;
    logic [DATA_WIDTH:0]   r_mag;

    logic signed [XW-1:0]  w_x0;
    logic signed [XW-1:0]  w_y0;
    logic signed [XW-1:0]  w_xs;
    logic signed [XW-1:0]  w_ys;
    logic signed [XW-1:0]  w_xr;
    logic [31:0]           w_zr;
    logic [PHI_WIDTH-1:0]  w_phase;
    logic [DATA_WIDTH:0]   w_mag;

    // atan(2^-i) as a fraction of the full circle, scaled to 2^32.
    function automatic logic [31:0] atanLut(input logic [4:0] idx);
        logic [31:0] v;
        case (idx)
            5'd0:  v = 32'h2000_0000;
            5'd1:  v = 32'h12E4_051E;
            5'd2:  v = 32'h09FB_385B;
            5'd3:  v = 32'h0511_11D4;
            5'd4:  v = 32'h028B_0D43;
            5'd5:  v = 32'h0145_D7E1;
            5'd6:  v = 32'h00A2_F61E;
            5'd7:  v = 32'h0051_7C55;
            5'd8:  v = 32'h0028_BE53;
            5'd9:  v = 32'h0014_5F2F;
            5'd10: v = 32'h000A_2F98;
            5'd11: v = 32'h0005_17CC;
            5'd12: v = 32'h0002_8BE6;
            5'd13: v = 32'h0001_45F3;
            5'd14: v = 32'h0000_A2FA;
            5'd15: v = 32'h0000_517D;
            5'd16: v = 32'h0000_28BE;
            5'd17: v = 32'h0000_145F;
            5'd18: v = 32'h0000_0A30;
            5'd19: v = 32'h0000_0518;
            5'd20: v = 32'h0000_028C;
            5'd21: v = 32'h0000_0146;
            5'd22: v = 32'h0000_00A3;
            5'd23: v = 32'h0000_0051;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    assign w_x0    = {{(XW-DATA_WIDTH-GUARD){r_cos[DATA_WIDTH-1]}}, r_cos, {GUARD{1'b0}}};
    assign w_y0    = {{(XW-DATA_WIDTH-GUARD){r_sin[DATA_WIDTH-1]}}, r_sin, {GUARD{1'b0}}};
    assign w_xs    = r_x >>> r_cnt;
    assign w_ys    = r_y >>> r_cnt;
    assign w_zr    = r_z + ROUND;
    assign w_phase = r_zero ? '0 : PHI_WIDTH'(w_zr >> (32 - PHI_WIDTH));
    assign w_xr    = r_x + HALF;
    assign w_mag   = w_xr[XW-1] ? '1 : (DATA_WIDTH+1)'(w_xr >>> GUARD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_PRE;
            end
            ST_PRE:  w_next = ST_ITER;
            ST_ITER: if (r_cnt == LAST) w_next = ST_DONE;
            ST_DONE: if (r_valid && out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // The first DONE cycle formats and registers the result; out_valid rises on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sin   <= '0;
            r_cos   <= '0;
            r_zero  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b1;
            r_phase <= '0;
            r_prev  <= '0;
            r_inc   <= '0;
            r_mag   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sin  <= sin_i;
                        r_cos  <= cos_i;
                        r_zero <= (sin_i == '0) && (cos_i == '0);
                    end
                end
                ST_PRE: begin
                    r_cnt <= '0;
                    if (w_x0[XW-1]) begin
                        r_x <= -w_x0;
                        r_y <= -w_y0;
                        r_z <= 32'h8000_0000;
                    end else begin
                        r_x <= w_x0;
                        r_y <= w_y0;
                        r_z <= 32'h0000_0000;
                    end
                end
                ST_ITER: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (!r_y[XW-1]) begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + atanLut(r_cnt);
                    end else begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - atanLut(r_cnt);
                    end
                end
                ST_DONE: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_phase <= w_phase;
                        r_mag   <= w_mag;
                        r_inc   <= r_first ? '0 : w_phase - r_prev;
                    end else if (out_ready) begin
                        r_valid <= 1'b0;
                        r_prev  <= r_phase;
                        r_first <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign phase_o   = r_phase;
    assign phi_inc_o = r_inc;
    assign mag_o     = r_mag;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_dsp_nco_phase_det.sv
// Scoreboard bench: stimulus pushes ideal atan2/hypot results, a negedge monitor checks every valid cycle.
`timescale 1ns/1ps

module tb_dsp_nco_phase_det;

    localparam int  DW    = 16;
    localparam int  PW    = 16;
    localparam int  NIT   = 16;
    localparam real PI    = 3.14159265358979323846;
    localparam real KGAIN = 1.64676;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic [DW-1:0] sin_i     = '0;
    logic [DW-1:0] cos_i     = '0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [PW-1:0] phase_o;
    logic [PW-1:0] phi_inc_o;
    logic [DW:0]   mag_o;
    logic          out_valid;
    logic          out_ready = 1'b1;

    typedef struct {
        real ph;
        real mag;
        real inc;
        bit  first;
        real phTol;
        real magTol;
        int  acceptCycle;
    } exp_t;

    exp_t expQ[$];
    int   checkCount  = 0;
    int   errorCount  = 0;
    int   cycleCount  = 0;
    bit   modelFirst  = 1'b1;
    real  modelPrev   = 0.0;
    bit   randomReady = 1'b0;
    bit   prevValid   = 1'b0;

    dsp_nco_phase_det #(
        .DATA_WIDTH(DW),
        .PHI_WIDTH (PW),
        .ITER      (NIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sin_i    (sin_i),
        .cos_i    (cos_i),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .phase_o  (phase_o),
        .phi_inc_o(phi_inc_o),
        .mag_o    (mag_o),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to measure accept-to-valid latency.
    always @(posedge clk) cycleCount++;

    // Random consumer backpressure, changed well away from the sampling edge.
    always @(posedge clk) begin
        #2;
        if (randomReady) out_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic real wrapPhase(input real p);
        real q;
        q = p;
        while (q < 0.0) q = q + 65536.0;
        while (q >= 65536.0) q = q - 65536.0;
        return q;
    endfunction

    task automatic checkOutput(input string name, input real act, input real req,
                               input real tol, input bit circ);
        real d;
        d = act - req;
        if (circ) begin
            while (d >= 32768.0) d = d - 65536.0;
            while (d < -32768.0) d = d + 65536.0;
        end
        if (d < 0.0) d = -d;
        checkCount++;
        if (d > tol) begin
            errorCount++;
            $display("[TB] FAIL %s: actual %0.2f, required %0.2f +/- %0.1f", name, act, req, tol);
        end
    endtask

    task automatic applyStimulus(input int s, input int c);
        exp_t e;
        real  r;
        int   waitCycles;
        waitCycles = 0;
        @(negedge clk);
        while (!in_ready && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 0.0, 1.0, 0.0, 1'b0);
            return;
        end
        sin_i    = DW'(s);
        cos_i    = DW'(c);
        in_valid = 1'b1;
        r        = $sqrt(real'(s) * real'(s) + real'(c) * real'(c));
        e.ph     = wrapPhase($atan2(real'(s), real'(c)) / (2.0 * PI) * 65536.0);
        e.mag    = KGAIN * r;
        e.phTol  = (s == 0 && c == 0) ? 0.0 : 3.0;
        e.magTol = (s == 0 && c == 0) ? 0.0 : 4.0;
        e.first  = modelFirst;
        e.inc    = modelFirst ? 0.0 : wrapPhase(e.ph - modelPrev);
        e.acceptCycle = cycleCount + 1;
        modelFirst = 1'b0;
        modelPrev  = e.ph;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic setReady(input bit v);
        @(posedge clk);
        #3;
        out_ready = v;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        while (expQ.size() > 0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() > 0) checkOutput("drain_timeout", real'(expQ.size()), 0.0, 0.0, 1'b0);
    endtask

    task automatic doReset(input int cycles);
        @(posedge clk);
        #3;
        rst = 1'b1;
        in_valid = 1'b0;
        expQ.delete();
        modelFirst = 1'b1;
        modelPrev  = 0.0;
        repeat (cycles) @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", real'(out_valid), 0.0, 0.0, 1'b0);
        checkOutput("reset_phase", real'(phase_o), 0.0, 0.0, 1'b0);
        checkOutput("reset_phi_inc", real'(phi_inc_o), 0.0, 0.0, 1'b0);
        checkOutput("reset_mag", real'(mag_o), 0.0, 0.0, 1'b0);
        checkOutput("reset_in_ready", real'(in_ready), 1.0, 0.0, 1'b0);
    endtask

    // Monitor: every valid cycle is compared against the queue head; a handshake pops it.
    always @(negedge clk) begin
        if (rst) begin
            prevValid = 1'b0;
        end else begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", 1.0, 0.0, 0.0, 1'b0);
                end else begin
                    exp_t e;
                    e = expQ[0];
                    if (!prevValid)
                        checkOutput("latency", real'(cycleCount - e.acceptCycle), real'(NIT + 2), 0.0, 1'b0);
                    checkOutput("phase", real'(phase_o), e.ph, e.phTol, 1'b1);
                    checkOutput("mag", real'(mag_o), e.mag, e.magTol, 1'b0);
                    if (e.first)
                        checkOutput("phi_inc_first", real'(phi_inc_o), 0.0, 0.0, 1'b0);
                    else
                        checkOutput("phi_inc", real'(phi_inc_o), e.inc, 6.0, 1'b1);
                    checkOutput("in_ready_busy", real'(in_ready), 0.0, 0.0, 1'b0);
                    if (out_ready) void'(expQ.pop_front());
                end
            end
            prevValid = out_valid;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checkCount, errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  w;
        int  s;
        int  c;
        int  a;
        int  amp;
        real ang;

        doReset(3);

        applyStimulus(0, 16384);
        applyStimulus(16384, 0);
        applyStimulus(0, -16384);
        applyStimulus(-16384, 0);
        applyStimulus(11585, 11585);
        applyStimulus(-32768, -32768);
        applyStimulus(0, 0);
        waitDrain(300);

        doReset(1);
        for (int k = 0; k < 20; k++) begin
            ang = 2.0 * PI * real'((k * 4096) % 65536) / 65536.0;
            applyStimulus(int'(30000.0 * $sin(ang)), int'(30000.0 * $cos(ang)));
        end
        waitDrain(300);

        setReady(1'b0);
        applyStimulus(12000, -7000);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) checkOutput("stall_valid_timeout", 0.0, 1.0, 0.0, 1'b0);
        repeat (10) @(negedge clk);
        setReady(1'b1);
        waitDrain(100);

        applyStimulus(5000, 9000);
        repeat (6) @(posedge clk);
        doReset(2);
        applyStimulus(-9000, 3000);
        applyStimulus(7000, 7000);
        waitDrain(200);

        randomReady = 1'b1;
        for (int n = 0; n < 30; n++) begin
            a   = int'($urandom_range(0, 65535));
            amp = int'($urandom_range(1000, 32000));
            ang = 2.0 * PI * real'(a) / 65536.0;
            s   = int'(real'(amp) * $sin(ang));
            c   = int'(real'(amp) * $cos(ang));
            applyStimulus(s, c);
        end
        waitDrain(2000);
        randomReady = 1'b0;
        setReady(1'b1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
